// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state type and GF(2^8) helpers; purely combinational.
// No latency or backpressure of its own: the S-box is computed as inverse-then-affine rather than read from a table.
package aes_pkg;

    localparam int         NR        = 10;
    localparam int         DATA_W    = 128;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_iter_ctrl_if.sv
// Host request/response bundle for the iterative AES controller; master is the host, slave the controller.
// No latency of its own; backpressure is the ready signal driven by the controller.
interface aes_iter_ctrl_if;
    import aes_pkg::*;

    logic              start;
    logic              ready;
    logic [DATA_W-1:0] plaintext_in;
    logic [DATA_W-1:0] key_in;
    logic [DATA_W-1:0] ciphertext_out;
    logic              done;
    logic              busy;
    logic [3:0]        round_idx;

    modport master (
        output start, plaintext_in, key_in,
        input  ready, ciphertext_out, done, busy, round_idx
    );

    modport slave (
        input  start, plaintext_in, key_in,
        output ready, ciphertext_out, done, busy, round_idx
    );

endinterface

// File: rtl/aes_round_unit.sv
// One AES round (SubBytes, ShiftRows, MixColumns unless last_round, AddRoundKey), purely combinational.
// Zero latency; no backpressure.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [DATA_W-1:0] state,
    input  logic [DATA_W-1:0] round_key,
    input  logic              last_round,
    output logic [DATA_W-1:0] next_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i is column i/4, row i%4, with byte 0 in the top bits of the bus.
    always_comb begin
        next_state = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            next_state[127-8*i -: 8] = (last_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round, ten cycles per block; done pulses after edge k+10 for accept at edge k.
// Backpressure via ready (low while running); AES_PENDING_EN adds a one-entry request buffer for 10-cycle throughput.
module aes_iter_ctrl
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    aes_iter_ctrl_if.slave host
);

    fsm_t              fsm;
    logic [DATA_W-1:0] state_q;
    logic [DATA_W-1:0] rkey_q;
    logic [DATA_W-1:0] next_key;
    logic [DATA_W-1:0] round_out;
    logic [DATA_W-1:0] ct_q;
    logic [7:0]        rcon_q;
    logic [3:0]        round_q;
    logic              done_q;
    logic              last_round;

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign next_key   = key_step(rkey_q, rcon_q);
    assign last_round = (round_q == 4'(NR));

    aes_round_unit u_round (
        .state      (state_q),
        .round_key  (next_key),
        .last_round (last_round),
        .next_state (round_out)
    );

`ifdef AES_PENDING_EN
    logic              pend_valid;
    logic [DATA_W-1:0] pend_pt;
    logic [DATA_W-1:0] pend_key;

    assign host.ready = !pend_valid;
`else
    assign host.ready = (fsm == IDLE);
`endif

    assign host.busy           = (fsm == RUN);
    assign host.done           = done_q;
    assign host.ciphertext_out = ct_q;
    assign host.round_idx      = round_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            rcon_q  <= '0;
            round_q <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
`ifdef AES_PENDING_EN
            pend_valid <= 1'b0;
            pend_pt    <= '0;
            pend_key   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (host.start) begin
                        state_q <= host.plaintext_in ^ host.key_in;
                        rkey_q  <= host.key_in;
                        rcon_q  <= RCON_INIT;
                        round_q <= 4'd1;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    rkey_q  <= next_key;
                    rcon_q  <= xtime(rcon_q);
                    round_q <= round_q + 4'd1;
                    if (last_round) begin
                        ct_q   <= round_out;
                        done_q <= 1'b1;
`ifdef AES_PENDING_EN
                        // A buffered request wins; otherwise a start on this edge chains directly.
                        if (pend_valid) begin
                            state_q    <= pend_pt ^ pend_key;
                            rkey_q     <= pend_key;
                            rcon_q     <= RCON_INIT;
                            round_q    <= 4'd1;
                            pend_valid <= 1'b0;
                        end else if (host.start) begin
                            state_q <= host.plaintext_in ^ host.key_in;
                            rkey_q  <= host.key_in;
                            rcon_q  <= RCON_INIT;
                            round_q <= 4'd1;
                        end else begin
                            fsm     <= IDLE;
                            round_q <= '0;
                        end
                    end else if (host.start && !pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_pt    <= host.plaintext_in;
                        pend_key   <= host.key_in;
`else
                        fsm     <= IDLE;
                        round_q <= '0;
`endif
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: transaction-level AES reference plus a cycle model of the handshake,
// compared on every cycle, with directed known-answer vectors and randomized traffic.
module tb_aes_iter_ctrl;

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    aes_iter_ctrl_if bus ();
    aes_iter_ctrl dut (.clk(clk), .rst(rst), .host(bus));

    always #5 clk = ~clk;

    logic [7:0] sbx [256];

    function automatic logic [7:0] m2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbx[tmp[23:16]], sbx[tmp[15:8]], sbx[tmp[7:0]], sbx[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = m2(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbx[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
                    s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Cycle model: ciphertext computed whole at acceptance, outputs derived from job progress.
    logic         m_busy, m_done, m_pend;
    int           m_round;
    logic [127:0] m_job, m_ct, m_pend_ct;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_pend <= 1'b0;
            m_round <= 0; m_ct <= '0; m_job <= '0; m_pend_ct <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy <= 1'b1; m_round <= 1;
                    m_job  <= aes_ref(bus.plaintext_in, bus.key_in);
                end
            end else if (m_round == 10) begin
                m_ct <= m_job; m_done <= 1'b1;
`ifdef AES_PENDING_EN
                if (m_pend) begin
                    m_job <= m_pend_ct; m_round <= 1; m_pend <= 1'b0;
                end else if (bus.start) begin
                    m_job <= aes_ref(bus.plaintext_in, bus.key_in); m_round <= 1;
                end else begin
                    m_busy <= 1'b0; m_round <= 0;
                end
`else
                m_busy <= 1'b0; m_round <= 0;
`endif
            end else begin
                m_round <= m_round + 1;
`ifdef AES_PENDING_EN
                if (bus.start && !m_pend) begin
                    m_pend <= 1'b1; m_pend_ct <= aes_ref(bus.plaintext_in, bus.key_in);
                end
`endif
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
`ifdef AES_PENDING_EN
            chk("ready", 128'(bus.ready), 128'(!m_pend));
`else
            chk("ready", 128'(bus.ready), 128'(!m_busy));
`endif
            chk("busy", 128'(bus.busy), 128'(m_busy));
            chk("done", 128'(bus.done), 128'(m_done));
            chk("round_idx", 128'(bus.round_idx), 128'(m_round));
            chk("ciphertext_out", bus.ciphertext_out, m_ct);
        end
    end

    task automatic wait_done(input string name, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (bus.done) return;
        end
        timeout(name);
    endtask

    task automatic wait_round(input string name, input int r);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.round_idx == 4'(r)) return;
        end
        timeout(name);
    endtask

    task automatic issue(input logic [127:0] pt, input logic [127:0] key);
        bus.start = 1'b1; bus.plaintext_in = pt; bus.key_in = key;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0]   x, inv, sv;
        logic [7:0]   ex [256];
        int           lg [256];
        int           n, dones;
        logic [127:0] rp, rk;

        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x; lg[x] = i; x = x ^ m2(x);
        end
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            sv  = 8'h63;
            for (int j = 0; j < 8; j++)
                sv[j] = sv[j] ^ inv[j] ^ inv[(j+4)%8] ^ inv[(j+5)%8] ^ inv[(j+6)%8] ^ inv[(j+7)%8];
            sbx[a] = sv;
        end
        chk("ref_appB", aes_ref(B_PT, B_KEY), B_CT);
        chk("ref_appC", aes_ref(C_PT, C_KEY), C_CT);

        bus.start = 1'b0; bus.plaintext_in = '0; bus.key_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(bus.ready), 128'd1);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_round", 128'(bus.round_idx), 128'd0);
        chk("rst_ct", bus.ciphertext_out, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known answer B with latency check
        issue(B_PT, B_KEY);
        wait_done("t1_done", n);
        chk("t1_latency", 128'(n), 128'd10);
        chk("t1_ct", bus.ciphertext_out, B_CT);
        @(negedge clk);
        chk("t1_busy_after", 128'(bus.busy), 128'd0);

        // Known answer C, then start held high with B
        issue(C_PT, C_KEY);
        bus.start = 1'b1; bus.plaintext_in = B_PT; bus.key_in = B_KEY;
        wait_done("t2_done_a", n);
        chk("t2_ct_a", bus.ciphertext_out, C_CT);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t2_done_b", n);
        chk("t2_gap", 128'(n + 1), 128'd11);
        chk("t2_ct_b", bus.ciphertext_out, B_CT);
        repeat (2) @(negedge clk);

        // start while busy is ignored (default build); one done per request
        rp = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        issue(rp, rk);
        wait_round("t3_r5", 5);
        issue(C_PT, C_KEY);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                chk("t3_ct", bus.ciphertext_out, aes_ref(rp, rk));
            end
        end
`ifndef AES_PENDING_EN
        chk("t3_dones", 128'(dones), 128'd1);
`endif

        // Async reset at round 7
        issue(C_PT, C_KEY);
        wait_round("t4_r7", 7);
        #2 rst = 1'b1;
        #1;
        chk("t4_done", 128'(bus.done), 128'd0);
        chk("t4_busy", 128'(bus.busy), 128'd0);
        chk("t4_round", 128'(bus.round_idx), 128'd0);
        chk("t4_ct", bus.ciphertext_out, 128'd0);
        chk("t4_ready", 128'(bus.ready), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(B_PT, B_KEY);
        wait_done("t4_restart", n);
        chk("t4_restart_ct", bus.ciphertext_out, B_CT);
        @(negedge clk);

        // Inputs scrambled after acceptance
        bus.start = 1'b1; bus.plaintext_in = C_PT; bus.key_in = C_KEY;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.plaintext_in = '1; bus.key_in = '1;
            chk($sformatf("t5_round%0d", j + 1), 128'(bus.round_idx), 128'(j + 1));
        end
        @(negedge clk);
        chk("t5_done", 128'(bus.done), 128'd1);
        chk("t5_ct", bus.ciphertext_out, C_CT);
        @(negedge clk);

`ifdef AES_PENDING_EN
        issue(B_PT, B_KEY);
        wait_round("t6_r3", 3);
        issue(C_PT, C_KEY);
        chk("t6_ready_low", 128'(bus.ready), 128'd0);
        wait_done("t6_done_a", n);
        chk("t6_ct_a", bus.ciphertext_out, B_CT);
        wait_done("t6_done_b", n);
        chk("t6_gap", 128'(n), 128'd10);
        chk("t6_ct_b", bus.ciphertext_out, C_CT);
        repeat (2) @(negedge clk);
`endif

        // Randomized traffic, checked by the per-cycle model
        for (int c = 0; c < 800; c++) begin
            bus.start        = ($urandom_range(0, 3) == 0);
            bus.plaintext_in = {$urandom, $urandom, $urandom, $urandom};
            bus.key_in       = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (25) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
Iterative AES-128 encryption controller that sequences a single shared round datapath over ten cycles, instead of ten unrolled round instances. It owns the start/ready/done handshake, the round counter, the Rcon sequence and on-the-fly round-key generation. It sits between the host request interface and the combinational round logic, and produces one ciphertext every 11 cycles in steady state.

Parameters:
NR, 10, number of AES rounds; fixed for AES-128, elaborates only with 10.
DATA_W, 128, block and key width in bits.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request strobe; accepted on an edge where start && ready.
ready  output  1  controller can accept a request this cycle.
plaintext_in  input  128  plaintext block; sampled only at acceptance.
key_in  input  128  cipher key; sampled only at acceptance.
ciphertext_out  output  128  last completed ciphertext; holds until the next completion.
done  output  1  one-cycle pulse, ciphertext_out valid and new.
busy  output  1  encryption in progress (FSM == RUN).
round_idx  output  4  current round 1..10 while busy; 0 in IDLE.

Behaviour:
- Clocking and reset: one clock clk; reset rst is asynchronous and active-high. The interface is fixed as decided.
- Reset values: ciphertext_out = 0, done = 0, busy = 0, ready = 1 (combinational from IDLE), round_idx = 0, state/key/rcon registers = 0, FSM = IDLE.
- FSM has two states, IDLE and RUN.
- IDLE: ready = 1. On start:
  - state_q <= plaintext_in ^ key_in.
  - rkey_q <= key_in.
  - rcon_q <= 8'h01.
  - round_idx <= 1.
  - FSM -> RUN.
- RUN: ready = 0. Each cycle:
  - next_key = KeyStep(rkey_q, rcon_q).
  - state_q <= Round(state_q, next_key).
  - rkey_q <= next_key.
  - rcon_q <= xtime(rcon_q), giving 01,02,04,08,10,20,40,80,1b,36.
  - round_idx increments.
- Rounds 1..9 apply SubBytes, ShiftRows, MixColumns and AddRoundKey. Round 10 omits MixColumns.
- Completion: on the edge where round_idx == 10:
  - ciphertext_out <= final result; done <= 1 for exactly one cycle.
  - FSM -> IDLE; round_idx <= 0.
- Latency: accept at edge k; done and ciphertext_out become visible after edge k+10.
- Back-to-back: ready is high in the cycle done is high, so the next accept can occur at edge k+11.
- start while busy: ignored, with no side effects.
- start held high: re-accepted on every cycle where ready = 1.
- Reset mid-operation: aborts immediately. No done pulse; ciphertext_out returns to 0.
- Plaintext/key inputs may change freely after acceptance without affecting the result.
- An all-zero ciphertext is legal. done is driven only by the FSM, never by a data compare.

Optional Feature:
AES_PENDING_EN
- With the macro: a one-entry pending buffer (pend_valid, pend_pt, pend_key).
  - ready = !pend_valid.
  - start during RUN is captured into the buffer.
  - At the completion edge, if pend_valid, the buffered request loads directly and the FSM stays in RUN, clearing pend_valid. done still pulses.
  - Throughput becomes one block per 10 cycles.
  - A start in IDLE bypasses the buffer.
  - Reset clears pend_valid.
- Without the macro: exact baseline behaviour as above; no buffer logic is present.

Decomposition:
- Package aes_pkg: NR, DATA_W, FSM state enum, RCON_INIT = 8'h01, xtime function, S-box function/constant table.
- One natural sub-module, aes_round_unit (combinational): inputs state, round key, last_round flag; output next state.
- KeyStep stays in the controller.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, start at edge 0 -> done pulse after edge 10, ciphertext_out = 3925841d02dc09fbdc118597196a0b32, busy low afterwards.
2. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Then hold start high with the App. B vector -> second done exactly 11 cycles after the first, with the correct ciphertext.
3. Pulse start at round_idx = 5 with different data -> ignored; current result unchanged, and only one done pulse.
4. Assert rst at round_idx = 7 -> all outputs reset asynchronously, no done pulse. Restart with the App. B vector -> correct result.
5. After acceptance, change plaintext_in/key_in to all-ones every cycle -> ciphertext still matches the accepted vector, and round_idx runs 1..10.
6. (AES_PENDING_EN) Accept vector A, send vector B at round_idx = 3 -> ready drops; done for A after edge 10, done for B after edge 20, both ciphertexts correct.
